// File: rtl/sign_narrow_sat_pkg.sv
// Shared narrowing helper: two's-complement IN->OUT width conversion with
// optional saturation, computed on a sign-extended MAX_W-bit carrier.
package sign_narrow_sat_pkg;

  localparam int MAX_W = 32;

  // Full-carrier extremes; shifting right by (MAX_W - w) yields the w-bit max/min.
  localparam logic [MAX_W-1:0] SAT_MAX = {1'b0, {(MAX_W-1){1'b1}}};
  localparam logic [MAX_W-1:0] SAT_MIN = {1'b1, {(MAX_W-1){1'b0}}};

  // sat sits in the LSB so a size cast to (w+1) bits gives {data[w-1:0], sat}.
  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic             sat;
  } narrow_t;

  function automatic narrow_t sat_narrow(input logic [MAX_W-1:0] in_sx,
                                         input logic             sat_en,
                                         input int unsigned      out_w);
    narrow_t          res;
    logic [MAX_W-1:0] upper;
    upper    = $signed(in_sx) >>> (out_w - 1);
    res.data = in_sx;
    res.sat  = 1'b0;
    if (sat_en && (upper != '0) && (upper != '1)) begin
      res.sat  = 1'b1;
      res.data = in_sx[MAX_W-1] ? (SAT_MIN >> (MAX_W - out_w))
                                : (SAT_MAX >> (MAX_W - out_w));
    end
    return res;
  endfunction

endpackage

// File: rtl/sign_narrow_sat_pipe_stage.sv
// One valid/ready register slice: accepts whenever empty or draining this cycle,
// holds its word stable while the consumer stalls.
module sign_narrow_sat_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // NOTE: state registers use non-blocking assignment; the data word is reset too so out_data reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sign_narrow_sat.sv
// Two-stage narrowing pipeline for write-back of wide results into narrow registers,
// with a sticky count of saturated words handed downstream.
module sign_narrow_sat
  import sign_narrow_sat_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int OUT_WIDTH   = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  input  logic                   in_sat_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  input  logic                   clear_count,
  output logic [COUNT_WIDTH-1:0] sat_count
);

  localparam int S1_W = IN_WIDTH + 1;
  localparam int S2_W = OUT_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  if ((IN_WIDTH <= OUT_WIDTH) || (OUT_WIDTH < 2) || (IN_WIDTH > MAX_W)) begin : g_param_check
    $error("sign_narrow_sat: requires MAX_W >= IN_WIDTH > OUT_WIDTH >= 2");
  end

  logic                s1_valid;
  logic                rdy2;
  logic [S1_W-1:0]     s1_bus;
  logic [IN_WIDTH-1:0] s1_data;
  logic                s1_sat_en;
  logic [MAX_W-1:0]    s1_sx;
  logic [S2_W-1:0]     s2_bus_d;
  logic [S2_W-1:0]     s2_bus_q;

  sign_narrow_sat_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sat_en, in_data}),
    .out_valid (s1_valid),
    .out_ready (rdy2),
    .out_data  (s1_bus)
  );

  assign {s1_sat_en, s1_data} = s1_bus;
  assign s1_sx    = MAX_W'($signed(s1_data));
  assign s2_bus_d = S2_W'(sat_narrow(s1_sx, s1_sat_en, OUT_WIDTH));

  // Stage 2 in_ready is rdy2, which is what lets stage 1 refill on a handoff edge.
  sign_narrow_sat_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (rdy2),
    .in_data   (s2_bus_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_bus_q)
  );

  assign {out_data, out_sat} = s2_bus_q;

  logic [COUNT_WIDTH-1:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (clear_count) begin
      sat_count_d = '0;
    end else if (out_valid && out_ready && out_sat && (sat_count_q != CNT_MAX)) begin
      sat_count_d = sat_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_count_q <= '0;
    else       sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;

endmodule
